// File: rtl/defuzz_pkg.sv
// Shared fuzzy-pipeline definitions: full-scale constants, defuzzifier sizing, FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package defuzz_pkg;

    // Crisp output full-scale (percent) and quotient width of the iterative divider.
    localparam int G_MAX_DEF  = 100;
    localparam int Q_BITS_DEF = 7;

    // Q1.15 operand width and full-scale value shared with the aggregation stage.
    localparam int          Q15_W    = 16;
    localparam logic [15:0] Q15_FULL = 16'h7FFF;

    // Width of the numerator S_wg*100; 0x7FFF*100 = 3276700 < 2^22.
    localparam int NUM_W = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Scale a Q1.15 value to percent units on NUM_W bits.
    function automatic logic [NUM_W-1:0] scale_pct(input logic [15:0] x);
        return NUM_W'(x) * NUM_W'(100);
    endfunction

    // Clip an operand to the legal Q1.15 range so the numerator cannot overflow.
    function automatic logic [15:0] q15_sat(input logic [15:0] x);
        return (x > Q15_FULL) ? Q15_FULL : x;
    endfunction

endpackage

// File: rtl/defuzz_div_restoring.sv
// Restoring divider: one quotient bit per clock, MSB first, started by a one-cycle start pulse.
// Latency: Q_BITS clocks after the start edge; 'last' is high in the cycle of the final iteration.
// Backpressure: none; a new start simply reloads the operands and restarts the division.
//
// Ports: clk/rst (sync, active-high); start loads num/den; last flags the final step;
//        quo is the Q_BITS-bit quotient, valid from the cycle after 'last'.
module div_restoring
    import defuzz_pkg::*;
#(
    parameter int Q_BITS = Q_BITS_DEF,
    parameter int DEN_W  = Q15_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_W-1:0]  num,
    input  logic [DEN_W-1:0]  den,
    output logic              last,
    output logic [Q_BITS-1:0] quo
);

    localparam int CNT_W = $clog2(Q_BITS + 1);
    localparam int REM_W = DEN_W + 1;

    logic [REM_W-1:0]  rem_q,  rem_d;
    logic [Q_BITS-1:0] bits_q, bits_d;   // numerator bits still to be shifted in, MSB first
    logic [Q_BITS-1:0] quo_q,  quo_d;
    logic [DEN_W-1:0]  den_q,  den_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;    // iterations remaining

    logic [REM_W:0]    trial;
    logic              fits;

    always_comb begin
        trial  = {rem_q, bits_q[Q_BITS-1]};
        fits   = trial >= (REM_W+1)'(den_q);

        rem_d  = rem_q;
        bits_d = bits_q;
        quo_d  = quo_q;
        den_d  = den_q;
        cnt_d  = cnt_q;

        if (start) begin
            // The upper numerator bits form the initial partial remainder; the
            // caller guarantees the quotient fits in Q_BITS, so this is < den.
            rem_d  = REM_W'(num >> Q_BITS);
            bits_d = num[Q_BITS-1:0];
            den_d  = den;
            quo_d  = '0;
            cnt_d  = CNT_W'(Q_BITS);
        end else if (cnt_q != '0) begin
            rem_d  = fits ? REM_W'(trial - (REM_W+1)'(den_q)) : REM_W'(trial);
            quo_d  = (quo_q << 1) | Q_BITS'(fits);
            bits_d = bits_q << 1;
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            bits_q <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            bits_q <= bits_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(1));
    assign quo  = quo_q;

endmodule

// File: rtl/defuzz.sv
// Defuzzifier: G_out = min(floor(S_wg*100 / S_w), G_MAX), den_zero flags S_w == 0.
// Latency: fixed Q_BITS+1 clocks from the acceptance edge to the registered valid_out pulse.
// Backpressure: busy while a request is in flight; valid_in during busy is dropped, not queued.
//
// Ports: clk, rst (sync, active-high); valid_in/S_w/S_wg request (Q1.15 operands);
//        busy (state != IDLE); valid_out one-cycle pulse with G_out/den_zero, which hold
//        their value until the next pulse.
module defuzz
    import defuzz_pkg::*;
#(
    parameter int G_MAX  = G_MAX_DEF,
    parameter int Q_BITS = Q_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] S_w,
    input  logic [15:0] S_wg,
    output logic        busy,
    output logic        valid_out,
    output logic [7:0]  G_out,
    output logic        den_zero
);

    state_t      state_q, state_d;
    logic        zero_q, zero_d;           // S_w == 0 for the request in flight
    logic        full_q, full_d;           // S_wg >= S_w: result saturates at G_MAX
    logic        valid_out_q, valid_out_d;
    logic [7:0]  g_out_q, g_out_d;
    logic        den_zero_q, den_zero_d;

    logic [15:0]       s_w_sat;
    logic [15:0]       s_wg_sat;
    logic [NUM_W-1:0]  num;
    logic              accept;
    logic              div_last;
    logic [Q_BITS-1:0] div_quo;
    logic [7:0]        quo_clamped;

    assign s_w_sat  = q15_sat(S_w);
    assign s_wg_sat = q15_sat(S_wg);
    assign num      = scale_pct(s_wg_sat);
    assign accept   = (state_q == ST_IDLE) && valid_in;

    // The divider runs for every request, including the fast cases, so the
    // latency is the same regardless of operand values.
    div_restoring #(
        .Q_BITS (Q_BITS),
        .DEN_W  (16)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .num   (num),
        .den   (s_w_sat),
        .last  (div_last),
        .quo   (div_quo)
    );

    always_comb begin
        if (int'(div_quo) > G_MAX) begin
            quo_clamped = 8'(G_MAX);
        end else begin
            quo_clamped = 8'(div_quo);
        end
    end

    always_comb begin
        state_d     = state_q;
        zero_d      = zero_q;
        full_d      = full_q;
        valid_out_d = 1'b0;
        g_out_d     = g_out_q;
        den_zero_d  = den_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    state_d = ST_CALC;
                    zero_d  = (s_w_sat == '0);
                    full_d  = (s_w_sat != '0) && (s_wg_sat >= s_w_sat);
                end
            end
            ST_CALC: begin
                if (div_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                valid_out_d = 1'b1;
                den_zero_d  = zero_q;
                if (zero_q) begin
                    g_out_d = '0;
                end else if (full_q) begin
                    g_out_d = 8'(G_MAX);
                end else begin
                    g_out_d = quo_clamped;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            zero_q      <= 1'b0;
            full_q      <= 1'b0;
            valid_out_q <= 1'b0;
            g_out_q     <= '0;
            den_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_q      <= zero_d;
            full_q      <= full_d;
            valid_out_q <= valid_out_d;
            g_out_q     <= g_out_d;
            den_zero_q  <= den_zero_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign valid_out = valid_out_q;
    assign G_out     = g_out_q;
    assign den_zero  = den_zero_q;

endmodule

// File: tb/tb_defuzz.sv
// Bench for defuzz: per-cycle comparison against a request-level model, plus literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_defuzz;

    localparam int QB  = 7;
    localparam int LAT = QB + 1;   // acceptance edge to valid_out, in clocks
    localparam int PER = QB + 2;   // minimum spacing between accepted requests
    localparam int GM  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [15:0] s_w = '0;
    logic [15:0] s_wg = '0;
    logic        busy;
    logic        valid_out;
    logic [7:0]  g_out;
    logic        den_zero;

    always #5 clk = ~clk;

    defuzz dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .S_w       (s_w),
        .S_wg      (s_wg),
        .busy      (busy),
        .valid_out (valid_out),
        .G_out     (g_out),
        .den_zero  (den_zero)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- request-level reference model ----------------
    function automatic int ref_g(input int sw, input int swg);
        int q;
        if (sw == 0) return 0;
        q = (swg * 100) / sw;
        return (q > GM) ? GM : q;
    endfunction

    int edge_k    = 0;
    bit started   = 0;
    bit pend      = 0;
    int done_edge = 0;
    int next_ok   = 0;
    int pend_g    = 0;
    int pend_dz   = 0;
    int exp_busy  = 0;
    int exp_vo    = 0;
    int exp_g     = 0;
    int exp_dz    = 0;

    always @(posedge clk) begin
        if (rst) begin
            started  = 1;
            pend     = 0;
            next_ok  = edge_k + 1;
            exp_busy = 0;
            exp_vo   = 0;
            exp_g    = 0;
            exp_dz   = 0;
        end else begin
            exp_vo = 0;
            if (pend && edge_k == done_edge) begin
                exp_vo  = 1;
                exp_g   = pend_g;
                exp_dz  = pend_dz;
                pend    = 0;
            end
            if (valid_in && edge_k >= next_ok) begin
                pend      = 1;
                done_edge = edge_k + LAT;
                next_ok   = edge_k + PER;
                pend_g    = ref_g(int'(s_w), int'(s_wg));
                pend_dz   = (s_w == 16'd0) ? 1 : 0;
            end
            exp_busy = (edge_k < next_ok - 1) ? 1 : 0;
        end
        edge_k++;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy",      int'(busy),      exp_busy);
            chk("valid_out", int'(valid_out), exp_vo);
            chk("G_out",     int'(g_out),     exp_g);
            chk("den_zero",  int'(den_zero),  exp_dz);
        end
    end

    // ---------------- directed helpers with literal expectations ----------------
    task automatic req(input logic [15:0] sw, input logic [15:0] swg,
                       input int eg, input int edz, input string nm);
        int lat;
        int busy_n;
        @(negedge clk);
        valid_in = 1'b1;
        s_w  = sw;
        s_wg = swg;
        @(negedge clk);                       // just after the acceptance edge
        valid_in = 1'b0;
        s_w  = 16'($urandom_range(0, 32767)); // operands are don't-care now
        s_wg = 16'($urandom_range(0, 32767));
        lat    = 0;
        busy_n = busy ? 1 : 0;
        while (!valid_out && lat < 4 * PER) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
        end
        chk({nm, "_latency"}, lat, LAT);
        chk({nm, "_busy_cycles"}, busy_n, LAT);
        chk({nm, "_G"}, int'(g_out), eg);
        chk({nm, "_dz"}, int'(den_zero), edz);
    endtask

    initial begin
        int pulses;
        int g_seen;
        int first_vo;
        int gap;

        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_vo",   int'(valid_out), 0);
        chk("reset_G",    int'(g_out), 0);
        chk("reset_dz",   int'(den_zero), 0);
        rst = 1'b0;

        req(16'h4000, 16'h2000, 50, 0, "half");
        req(16'h0003, 16'h0001, 33, 0, "trunc33");
        req(16'h7FFF, 16'h7FFE, 99, 0, "trunc99");
        req(16'h1000, 16'h7FFF, 100, 0, "sat");

        // Extra valid_in pulses (in CALC and in DONE) must not disturb or queue.
        @(negedge clk);
        valid_in = 1'b1;
        s_w  = 16'h4000;
        s_wg = 16'h2000;
        pulses = 0;
        g_seen = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (valid_out) begin
                pulses++;
                g_seen = int'(g_out);
            end
            valid_in = (c == 3 || c == 8);
            s_w  = 16'h0100;
            s_wg = 16'h7000;
        end
        valid_in = 1'b0;
        chk("ignore_pulses", pulses, 1);
        chk("ignore_G", g_seen, 50);

        // Continuous valid_in: results come out exactly PER clocks apart.
        @(negedge clk);
        valid_in = 1'b1;
        s_w  = 16'h0200;
        s_wg = 16'h0100;
        first_vo = -1;
        gap = -1;
        for (int c = 1; c <= 3 * PER; c++) begin
            @(negedge clk);
            if (valid_out) begin
                if (first_vo < 0) first_vo = c;
                else if (gap < 0) gap = c - first_vo;
            end
        end
        valid_in = 1'b0;
        chk("throughput_gap", gap, PER);

        req(16'h0000, 16'h1234, 0, 1, "zero_den");

        // Reset four clocks after acceptance aborts the request.
        @(negedge clk);
        valid_in = 1'b1;
        s_w  = 16'h4000;
        s_wg = 16'h2000;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            valid_in = 1'b0;
            if (c == 4) rst = 1'b1;
            if (c == 5) rst = 1'b0;
        end
        chk("abort_busy", int'(busy), 0);
        chk("abort_G",    int'(g_out), 0);
        chk("abort_dz",   int'(den_zero), 0);
        req(16'h4000, 16'h1000, 25, 0, "after_rst");

        // Randomized traffic, including occasional reset (sometimes with valid_in).
        for (int i = 0; i < 3000; i++) begin
            int sw;
            int swg;
            int r;
            @(negedge clk);
            rst      = ($urandom_range(0, 199) == 0);
            valid_in = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            if (r == 0)      sw = 0;
            else if (r == 1) sw = $urandom_range(1, 16);
            else             sw = $urandom_range(1, 32767);
            r = $urandom_range(0, 9);
            if (r == 0)                 swg = 0;
            else if (r == 1)            swg = sw;
            else if (r == 2)            swg = 32767;
            else if (r < 7 && sw > 0)   swg = $urandom_range(0, sw - 1);
            else                        swg = $urandom_range(0, 32767);
            s_w  = 16'(sw);
            s_wg = 16'(swg);
        end
        @(negedge clk);
        rst = 1'b0;
        valid_in = 1'b0;
        repeat (2 * PER) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
